// File: rtl/hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// hazard_ctrl_if
//
// Bundles every pipeline-facing signal of the hazard controller so the
// datapath and the controller connect through a single port.
//
//   slave  modport : used by hazard_ctrl (register addresses, write enables,
//                    result select, branch and cache-miss status in;
//                    forwarding selects, stall/flush controls and the
//                    miss-sequencer status out).
//   master modport : used by the pipeline datapath (the mirror image).
//
// Parameter:
//   REG_ADDR_WIDTH - width of register-file addresses.
// ---------------------------------------------------------------------------
interface hazard_ctrl_if #(
    parameter int unsigned REG_ADDR_WIDTH = 5
);
    // Register addresses and write enables seen by the hazard logic
    logic [REG_ADDR_WIDTH-1:0] rs1D_i;
    logic [REG_ADDR_WIDTH-1:0] rs2D_i;
    logic [REG_ADDR_WIDTH-1:0] rs1E_i;
    logic [REG_ADDR_WIDTH-1:0] rs2E_i;
    logic [REG_ADDR_WIDTH-1:0] rdE_i;
    logic [REG_ADDR_WIDTH-1:0] rdM_i;
    logic [REG_ADDR_WIDTH-1:0] rdW_i;
    logic                      reg_writeM_i;
    logic                      reg_writeW_i;
    logic [1:0]                result_srcE_i;
    logic                      pc_srcE_i;
    logic                      cache_missM_i;

    // Controls driven back into the pipeline
    logic [1:0]                forward_aE_o;
    logic [1:0]                forward_bE_o;
    logic                      stallF_o;
    logic                      stallD_o;
    logic                      stallE_o;
    logic                      stallM_o;
    logic                      flushD_o;
    logic                      flushE_o;
    logic                      flushW_o;
    logic                      cache_refill_o;
    logic                      miss_busy_o;

    modport slave (
        input  rs1D_i, rs2D_i, rs1E_i, rs2E_i, rdE_i, rdM_i, rdW_i,
        input  reg_writeM_i, reg_writeW_i, result_srcE_i, pc_srcE_i,
        input  cache_missM_i,
        output forward_aE_o, forward_bE_o,
        output stallF_o, stallD_o, stallE_o, stallM_o,
        output flushD_o, flushE_o, flushW_o,
        output cache_refill_o, miss_busy_o
    );

    modport master (
        output rs1D_i, rs2D_i, rs1E_i, rs2E_i, rdE_i, rdM_i, rdW_i,
        output reg_writeM_i, reg_writeW_i, result_srcE_i, pc_srcE_i,
        output cache_missM_i,
        input  forward_aE_o, forward_bE_o,
        input  stallF_o, stallD_o, stallE_o, stallM_o,
        input  flushD_o, flushE_o, flushW_o,
        input  cache_refill_o, miss_busy_o
    );
endinterface

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
//
// Central hazard controller for the 5-stage pipeline: RAW forwarding selects
// for the E-stage ALU operands, load-use stall, taken branch/jump flush, and
// a data-cache miss sequencer (IDLE -> WAIT -> FILL) that freezes the whole
// pipeline until the refill line has been written.
//
// Ports:
//   clk_i          - clock, rising edge
//   rst_ni         - asynchronous active-low reset
//   hz             - hazard_ctrl_if.slave, all pipeline-facing signals
//   stall_cycles_o - (HAZARD_PERF_EN only) saturating count of stallF cycles
//   miss_count_o   - (HAZARD_PERF_EN only) saturating count of cache misses
//
// Parameters:
//   MISS_LATENCY   - cycles spent in WAIT before the refill cycle (>= 1)
//   REG_ADDR_WIDTH - register-address width, must match the interface
//   PERF_WIDTH     - width of the optional performance counters
//
// Optional feature: define HAZARD_PERF_EN to add the performance counters.
// ---------------------------------------------------------------------------
module hazard_ctrl #(
    parameter int unsigned MISS_LATENCY   = 4,
    parameter int unsigned REG_ADDR_WIDTH = 5,
    parameter int unsigned PERF_WIDTH     = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
`ifdef HAZARD_PERF_EN
    output logic [PERF_WIDTH-1:0] stall_cycles_o,
    output logic [PERF_WIDTH-1:0] miss_count_o,
`endif
    hazard_ctrl_if.slave          hz
);

    localparam int unsigned CNT_W = $clog2(MISS_LATENCY + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_FILL = 2'd2
    } miss_state_e;

    // Elaboration-time parameter sanity check
    generate
        if (MISS_LATENCY < 1 || PERF_WIDTH < 1) begin : g_bad_params
            $error("hazard_ctrl: MISS_LATENCY and PERF_WIDTH must be >= 1");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Local copies of the register addresses at the declared width
    // ------------------------------------------------------------------
    logic [REG_ADDR_WIDTH-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;

    assign rs1_d = hz.rs1D_i;
    assign rs2_d = hz.rs2D_i;
    assign rs1_e = hz.rs1E_i;
    assign rs2_e = hz.rs2E_i;
    assign rd_e  = hz.rdE_i;
    assign rd_m  = hz.rdM_i;
    assign rd_w  = hz.rdW_i;

    // ------------------------------------------------------------------
    // RAW forwarding: the M-stage result is newer than W, so it wins.
    // x0 is hard-wired to zero and never forwarded.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default first so that no
        // path through the block leaves it unassigned and infers a latch.
        hz.forward_aE_o = 2'b00;
        hz.forward_bE_o = 2'b00;

        if (hz.reg_writeM_i && rd_m != '0 && rd_m == rs1_e)
            hz.forward_aE_o = 2'b10;
        else if (hz.reg_writeW_i && rd_w != '0 && rd_w == rs1_e)
            hz.forward_aE_o = 2'b01;

        if (hz.reg_writeM_i && rd_m != '0 && rd_m == rs2_e)
            hz.forward_bE_o = 2'b10;
        else if (hz.reg_writeW_i && rd_w != '0 && rd_w == rs2_e)
            hz.forward_bE_o = 2'b01;
    end

    // Load in E whose destination is a source of the instruction in D
    logic lw_stall;
    assign lw_stall = (hz.result_srcE_i == 2'b01) && (rd_e != '0) &&
                      ((rd_e == rs1_d) || (rd_e == rs2_d));

    // ------------------------------------------------------------------
    // Data-cache miss sequencer
    // ------------------------------------------------------------------
    miss_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             refill;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples its inputs from before the clock edge.
        if (!rst_ni) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        refill  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (hz.cache_missM_i) begin
                    state_d = S_WAIT;
                    cnt_d   = CNT_W'(MISS_LATENCY - 1);
                end
            end
            S_WAIT: begin
                // New miss requests are ignored until the sequence ends
                if (cnt_q == '0) state_d = S_FILL;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            S_FILL: begin
                refill  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Combinational so the very first miss cycle already freezes the pipe
    logic miss_busy;
    assign miss_busy = (state_q != S_IDLE) ||
                       ((state_q == S_IDLE) && hz.cache_missM_i);

    // ------------------------------------------------------------------
    // Stall / flush controls. A miss dominates: E is frozen, so a pending
    // branch or load-use re-presents on the first cycle after FILL.
    // ------------------------------------------------------------------
    assign hz.stallF_o       = lw_stall | miss_busy;
    assign hz.stallD_o       = lw_stall | miss_busy;
    assign hz.stallE_o       = miss_busy;
    assign hz.stallM_o       = miss_busy;
    assign hz.flushW_o       = miss_busy;
    assign hz.flushD_o       = hz.pc_srcE_i & ~miss_busy;
    assign hz.flushE_o       = (lw_stall | hz.pc_srcE_i) & ~miss_busy;
    assign hz.cache_refill_o = refill;
    assign hz.miss_busy_o    = miss_busy;

`ifdef HAZARD_PERF_EN
    // ------------------------------------------------------------------
    // Saturating performance counters
    // ------------------------------------------------------------------
    logic [PERF_WIDTH-1:0] stall_cycles_q, miss_count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_cycles_q <= '0;
            miss_count_q   <= '0;
        end else begin
            if (hz.stallF_o && stall_cycles_q != '1)
                stall_cycles_q <= stall_cycles_q + PERF_WIDTH'(1);
            if (state_q == S_IDLE && hz.cache_missM_i && miss_count_q != '1)
                miss_count_q <= miss_count_q + PERF_WIDTH'(1);
        end
    end

    assign stall_cycles_o = stall_cycles_q;
    assign miss_count_o   = miss_count_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
//
// Directed self-checking bench for hazard_ctrl (MISS_LATENCY = 4).
// Inputs change 1 time unit after a rising edge; outputs are checked one
// further unit later, well away from the active edge.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    hazard_ctrl_if #(.REG_ADDR_WIDTH(5)) hz ();

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cycles;
    logic [31:0] miss_count;
`endif

    hazard_ctrl #(
        .MISS_LATENCY  (4),
        .REG_ADDR_WIDTH(5),
        .PERF_WIDTH    (32)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
`ifdef HAZARD_PERF_EN
        .stall_cycles_o(stall_cycles),
        .miss_count_o  (miss_count),
`endif
        .hz            (hz)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        hz.rs1D_i        = '0;
        hz.rs2D_i        = '0;
        hz.rs1E_i        = '0;
        hz.rs2E_i        = '0;
        hz.rdE_i         = '0;
        hz.rdM_i         = '0;
        hz.rdW_i         = '0;
        hz.reg_writeM_i  = 1'b0;
        hz.reg_writeW_i  = 1'b0;
        hz.result_srcE_i = 2'b00;
        hz.pc_srcE_i     = 1'b0;
        hz.cache_missM_i = 1'b0;
    endtask

    initial begin
        clear_inputs();

        // ---------------- reset state ----------------
        #2;
        check("rst_busy",   32'(hz.miss_busy_o),    32'd0);
        check("rst_refill", 32'(hz.cache_refill_o), 32'd0);
        check("rst_stallF", 32'(hz.stallF_o),       32'd0);
        check("rst_flushE", 32'(hz.flushE_o),       32'd0);
        hz.cache_missM_i = 1'b1;
        #1;
        check("rst_busy_miss", 32'(hz.miss_busy_o), 32'd1);
        hz.cache_missM_i = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // ---------------- forwarding ----------------
        hz.rdM_i = 5'd5; hz.reg_writeM_i = 1'b1;
        hz.rdW_i = 5'd5; hz.reg_writeW_i = 1'b1;
        hz.rs1E_i = 5'd5; hz.rs2E_i = 5'd5;
        #1;
        check("fwdA_M_prio", 32'(hz.forward_aE_o), 32'd2);
        check("fwdB_M_prio", 32'(hz.forward_bE_o), 32'd2);
        hz.reg_writeM_i = 1'b0;
        #1;
        check("fwdA_W", 32'(hz.forward_aE_o), 32'd1);
        check("fwdB_W", 32'(hz.forward_bE_o), 32'd1);
        hz.reg_writeM_i = 1'b1; hz.rdM_i = 5'd0; hz.rdW_i = 5'd0;
        hz.rs1E_i = 5'd0; hz.rs2E_i = 5'd0;
        #1;
        check("fwdA_x0", 32'(hz.forward_aE_o), 32'd0);
        check("fwdB_x0", 32'(hz.forward_bE_o), 32'd0);
        hz.rdM_i = 5'd3; hz.rdW_i = 5'd4; hz.rs1E_i = 5'd4; hz.rs2E_i = 5'd3;
        #1;
        check("fwdA_split", 32'(hz.forward_aE_o), 32'd1);
        check("fwdB_split", 32'(hz.forward_bE_o), 32'd2);
        hz.rs1E_i = 5'd9; hz.rs2E_i = 5'd10;
        #1;
        check("fwdA_none", 32'(hz.forward_aE_o), 32'd0);
        check("fwdB_none", 32'(hz.forward_bE_o), 32'd0);
        clear_inputs();

        // ---------------- load-use ----------------
        tick();
        hz.result_srcE_i = 2'b01; hz.rdE_i = 5'd7; hz.rs2D_i = 5'd7;
        #1;
        check("lu_stallF", 32'(hz.stallF_o), 32'd1);
        check("lu_stallD", 32'(hz.stallD_o), 32'd1);
        check("lu_flushE", 32'(hz.flushE_o), 32'd1);
        check("lu_flushD", 32'(hz.flushD_o), 32'd0);
        check("lu_stallE", 32'(hz.stallE_o), 32'd0);
        hz.rs2D_i = 5'd0; hz.rs1D_i = 5'd7;
        #1;
        check("lu_rs1_stallF", 32'(hz.stallF_o), 32'd1);
        hz.rdE_i = 5'd0; hz.rs1D_i = 5'd0;
        #1;
        check("lu_x0_stallF", 32'(hz.stallF_o), 32'd0);
        check("lu_x0_flushE", 32'(hz.flushE_o), 32'd0);
        hz.rdE_i = 5'd7; hz.rs1D_i = 5'd7; hz.result_srcE_i = 2'b00;
        #1;
        check("alu_no_stall", 32'(hz.stallF_o), 32'd0);
        clear_inputs();

        // ---------------- branch flush ----------------
        tick();
        hz.pc_srcE_i = 1'b1;
        #1;
        check("br_flushD", 32'(hz.flushD_o), 32'd1);
        check("br_flushE", 32'(hz.flushE_o), 32'd1);
        check("br_stallF", 32'(hz.stallF_o), 32'd0);
        check("br_stallE", 32'(hz.stallE_o), 32'd0);
        hz.result_srcE_i = 2'b01; hz.rdE_i = 5'd6; hz.rs1D_i = 5'd6;
        #1;
        check("brlu_flushD", 32'(hz.flushD_o), 32'd1);
        check("brlu_flushE", 32'(hz.flushE_o), 32'd1);
        check("brlu_stallF", 32'(hz.stallF_o), 32'd1);
        clear_inputs();

        // ---------------- single miss ----------------
        tick();
        hz.cache_missM_i = 1'b1;
        #1;
        check("miss_c1_busy",   32'(hz.miss_busy_o),    32'd1);
        check("miss_c1_refill", 32'(hz.cache_refill_o), 32'd0);
        check("miss_c1_stallE", 32'(hz.stallE_o),       32'd1);
        check("miss_c1_stallM", 32'(hz.stallM_o),       32'd1);
        check("miss_c1_flushW", 32'(hz.flushW_o),       32'd1);
        check("miss_c1_stallF", 32'(hz.stallF_o),       32'd1);
        tick();
        hz.cache_missM_i = 1'b0;
        for (int c = 2; c <= 6; c++) begin
            #1;
            check($sformatf("miss_c%0d_busy", c),   32'(hz.miss_busy_o), 32'd1);
            check($sformatf("miss_c%0d_refill", c), 32'(hz.cache_refill_o),
                  (c == 6) ? 32'd1 : 32'd0);
            check($sformatf("miss_c%0d_stallE", c), 32'(hz.stallE_o), 32'd1);
            check($sformatf("miss_c%0d_flushW", c), 32'(hz.flushW_o), 32'd1);
            tick();
        end
        #1;
        check("miss_c7_busy",   32'(hz.miss_busy_o),    32'd0);
        check("miss_c7_refill", 32'(hz.cache_refill_o), 32'd0);
        check("miss_c7_stallE", 32'(hz.stallE_o),       32'd0);

        // ---------------- miss with branch held ----------------
        tick();
        hz.pc_srcE_i = 1'b1;
        hz.cache_missM_i = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            #1;
            check($sformatf("mbr_c%0d_flushD", c), 32'(hz.flushD_o), 32'd0);
            check($sformatf("mbr_c%0d_flushE", c), 32'(hz.flushE_o), 32'd0);
            tick();
            hz.cache_missM_i = 1'b0;
        end
        #1;
        check("mbr_c7_flushD", 32'(hz.flushD_o),    32'd1);
        check("mbr_c7_flushE", 32'(hz.flushE_o),    32'd1);
        check("mbr_c7_busy",   32'(hz.miss_busy_o), 32'd0);
        clear_inputs();

        // ---------------- reset during WAIT ----------------
        tick();
        hz.cache_missM_i = 1'b1;
        tick();
        hz.cache_missM_i = 1'b0;
        tick();
        check("rw_busy_pre", 32'(hz.miss_busy_o), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rw_busy_rst",   32'(hz.miss_busy_o),    32'd0);
        check("rw_refill_rst", 32'(hz.cache_refill_o), 32'd0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rw_refill_hold", 32'(hz.cache_refill_o), 32'd0);
        end
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            check("rw_refill_after", 32'(hz.cache_refill_o), 32'd0);
            check("rw_busy_after",   32'(hz.miss_busy_o),    32'd0);
        end

`ifdef HAZARD_PERF_EN
        check("perf_miss_rst",  miss_count,   32'd0);
        check("perf_stall_rst", stall_cycles, 32'd0);
        hz.cache_missM_i = 1'b1;
        tick();
        hz.cache_missM_i = 1'b0;
        repeat (5) tick();
        check("perf_miss_one",  miss_count,   32'd1);
        check("perf_stall_six", stall_cycles, 32'd6);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Central hazard controller for the 5-stage pipeline. Drives the stall and flush inputs of the F/D, D/E, E/M and M/W pipeline registers, and the E-stage forwarding muxes.
- Handles RAW forwarding, load-use stalls and taken branch/jump flushes.
- Runs a multi-cycle data-cache miss sequencer that freezes the pipeline until the refill completes.

Parameters:
- MISS_LATENCY, 4, cycles spent in WAIT before refill. Must be >= 1.
- REG_ADDR_WIDTH, 5, width of register-file addresses.
- PERF_WIDTH, 32, width of the performance counters (used only with the optional feature).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  reset. Asynchronous, active-low.
- rs1D_i  in  REG_ADDR_WIDTH  source reg 1 (decode).
- rs2D_i  in  REG_ADDR_WIDTH  source reg 2 (decode).
- rs1E_i  in  REG_ADDR_WIDTH  source reg 1 (execute).
- rs2E_i  in  REG_ADDR_WIDTH  source reg 2 (execute).
- rdE_i  in  REG_ADDR_WIDTH  destination reg (execute).
- rdM_i  in  REG_ADDR_WIDTH  destination reg (memory).
- rdW_i  in  REG_ADDR_WIDTH  destination reg (writeback).
- reg_writeM_i  in  1  M-stage register write enable.
- reg_writeW_i  in  1  W-stage register write enable.
- result_srcE_i  in  2  E-stage result select. 2'b01 = load.
- pc_srcE_i  in  1  branch taken or jump in E.
- cache_missM_i  in  1  data-cache miss for the M-stage access.
- forward_aE_o  out  2  ALU operand A source: 00 reg file, 01 W result, 10 M ALU result.
- forward_bE_o  out  2  ALU operand B source, same encoding as forward_aE_o.
- stallF_o  out  1  hold PC.
- stallD_o  out  1  hold F/D register.
- stallE_o  out  1  hold D/E register.
- stallM_o  out  1  hold E/M register.
- flushD_o  out  1  clear F/D register.
- flushE_o  out  1  clear D/E register.
- flushW_o  out  1  clear M/W register (bubble).
- cache_refill_o  out  1  one-cycle strobe: cache writes the fetched line.
- miss_busy_o  out  1  miss sequence in progress.

Behaviour:
- Forwarding (combinational):
  - forward_aE_o = 10 if reg_writeM_i & rdM_i!=0 & rdM_i==rs1E_i.
  - Otherwise 01 if reg_writeW_i & rdW_i!=0 & rdW_i==rs1E_i.
  - Otherwise 00.
  - M has priority over W. forward_bE_o is identical but uses rs2E_i.
- Load-use: lw_stall = (result_srcE_i==2'b01) & rdE_i!=0 & (rdE_i==rs1D_i | rdE_i==rs2D_i).
- Miss FSM states: IDLE, WAIT, FILL. Counter width is $clog2(MISS_LATENCY+1).
  - IDLE: if cache_missM_i, then on the next edge go to WAIT and load cnt=MISS_LATENCY-1.
  - WAIT: if cnt==0, go to FILL; otherwise cnt-1.
  - FILL: cache_refill_o=1; go to IDLE on the next edge.
  - cache_missM_i is ignored in WAIT and FILL.
- miss_busy_o = (state!=IDLE) | (state==IDLE & cache_missM_i). It is combinational, so the first miss cycle already stalls.
- A miss costs MISS_LATENCY+2 stalled cycles in total.
- Outputs:
  - stallF_o = stallD_o = lw_stall | miss_busy_o.
  - stallE_o = stallM_o = miss_busy_o.
  - flushW_o = miss_busy_o.
  - flushD_o = pc_srcE_i & ~miss_busy_o.
  - flushE_o = (lw_stall | pc_srcE_i) & ~miss_busy_o.
- Simultaneous events:
  - Miss dominates. Branch flush and load-use bubble are deferred.
  - E is frozen during a miss, so pc_srcE_i and lw_stall re-present on the first cycle after FILL and then take effect.
- lw_stall together with pc_srcE_i: flushD_o and flushE_o both 1, stallF_o 1. The branch target loads on the next unstalled cycle.
- Reset:
  - rst_ni low forces state=IDLE and cnt=0 asynchronously, so cache_refill_o=0.
  - miss_busy_o is 0 unless cache_missM_i=1.
  - The remaining outputs are pure combinational functions of their inputs.
  - Reset asserted mid-miss abandons the sequence immediately; no refill strobe is issued.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined: adds outputs stall_cycles_o and miss_count_o, each PERF_WIDTH bits.
  - stall_cycles_o increments every cycle stallF_o=1.
  - miss_count_o increments on each IDLE->WAIT transition.
  - Both saturate at all-ones and clear on reset.
- Undefined: the ports and counters do not exist. Core behaviour is identical.

Test Plan:
- rdM=5, reg_writeM=1, rs1E=5; also rdW=5, reg_writeW=1 -> forward_aE_o=10. Drop reg_writeM -> forward_aE_o=01. Set rdM=rdW=0 -> 00.
- result_srcE=01, rdE=7, rs2D=7 -> stallF=stallD=flushE=1, flushD=0, one cycle. Same with rdE=0 -> no stall.
- pc_srcE=1, no miss -> flushD=flushE=1, stalls 0.
- MISS_LATENCY=4, cache_missM=1 for one cycle -> miss_busy=1 for 6 cycles, cache_refill_o=1 only in cycle 6, stallE=stallM=flushW=1 throughout.
- Miss with pc_srcE=1 held -> flushD/flushE=0 during all 6 cycles, then 1 on cycle 7.
- rst_ni low during the WAIT state -> state IDLE immediately, no cache_refill_o. With HAZARD_PERF_EN, miss_count_o=0 after reset and 1 after a later miss.
